// File: rtl/skew_stb_gen.sv
// Strobe generator and comparator majority-vote sampler for the skew measurement path.
// Optional SKEW_STB_STATS_EN adds ones_cnt_o with the final ones count of each vote.
module skew_stb_gen #(
    parameter int PULSE_W     = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int NUM_SAMPLES = 15,
    parameter int SYNC_STAGES = 2,
    localparam int MAX_PS  = (PULSE_W > SETTLE_CYC) ? PULSE_W : SETTLE_CYC,
    localparam int MAX_CYC = (MAX_PS > NUM_SAMPLES) ? MAX_PS : NUM_SAMPLES,
    localparam int CW      = $clog2(MAX_CYC + 1)
) (
    input  logic          clk_i,
    input  logic          arstn_i,
    input  logic          stb_req_i,
    output logic          stb_o,
    input  logic          cmp_raw_i,
    output logic          stb_valid_o,
    output logic          cmp_out_o,
    output logic          busy_o,
`ifdef SKEW_STB_STATS_EN
    output logic [CW-1:0] ones_cnt_o,
`endif
    output logic          ovr_o,
    input  logic          ovr_clr_i
);

    // state  | meaning
    // IDLE   | waiting for stb_req_i
    // FIRE   | stb_o high for PULSE_W cycles
    // SETTLE | measured path settling for SETTLE_CYC cycles
    // SAMPLE | counting cmp_s ones for NUM_SAMPLES cycles
    // DONE   | one-cycle stb_valid_o with voted result
    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        ones_q, ones_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 cmp_s;
    logic                 stb_q, valid_q, cmp_q, busy_q, ovr_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_raw_i};
        end
    end

    assign cmp_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
        end
    end

    // Phase timer is a down-counter loaded with (length-1) on entry to each phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                ones_d = '0;
                if (stb_req_i) begin
                    state_d = FIRE;
                    cnt_d   = CW'(PULSE_W - 1);
                end
            end
            FIRE: begin
                if (cnt_q == '0) begin
                    if (SETTLE_CYC == 0) begin
                        state_d = SAMPLE;
                        cnt_d   = CW'(NUM_SAMPLES - 1);
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = CW'(SETTLE_CYC - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                    cnt_d   = CW'(NUM_SAMPLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                ones_d = ones_q + CW'(cmp_s);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ones_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state they describe.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            stb_q   <= 1'b0;
            valid_q <= 1'b0;
            cmp_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            stb_q   <= (state_d == FIRE);
            valid_q <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
            if (state_d == DONE) begin
                cmp_q <= (ones_d > CW'(NUM_SAMPLES / 2));
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ovr_q <= 1'b0;
        end else if (stb_req_i && (state_q != IDLE)) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr_i) begin
            ovr_q <= 1'b0;
        end
    end

`ifdef SKEW_STB_STATS_EN
    logic [CW-1:0] ones_cnt_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ones_cnt_q <= '0;
        end else if (state_d == DONE) begin
            ones_cnt_q <= ones_d;
        end
    end

    assign ones_cnt_o = ones_cnt_q;
`endif

    assign stb_o       = stb_q;
    assign stb_valid_o = valid_q;
    assign cmp_out_o   = cmp_q;
    assign busy_o      = busy_q;
    assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_skew_stb_gen.sv
// Randomized bench for skew_stb_gen: two instances (15 and 16 samples) against a window-based reference model.
module tb_skew_stb_gen;

    localparam int P   = 4;
    localparam int S   = 8;
    localparam int N0  = 15;
    localparam int N1  = 16;
    localparam int CW0 = 4;
    localparam int CW1 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arstn, stb_req, cmp_raw, ovr_clr;
    logic stb0, val0, cmp0, busy0, ovr0;
    logic stb1, val1, cmp1, busy1, ovr1;
`ifdef SKEW_STB_STATS_EN
    logic [CW0-1:0] ones0;
    logic [CW1-1:0] ones1;
`endif

    skew_stb_gen #(.PULSE_W(P), .SETTLE_CYC(S), .NUM_SAMPLES(N0), .SYNC_STAGES(2)) u_dut0 (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .stb_req_i  (stb_req),
        .stb_o      (stb0),
        .cmp_raw_i  (cmp_raw),
        .stb_valid_o(val0),
        .cmp_out_o  (cmp0),
        .busy_o     (busy0),
`ifdef SKEW_STB_STATS_EN
        .ones_cnt_o (ones0),
`endif
        .ovr_o      (ovr0),
        .ovr_clr_i  (ovr_clr)
    );

    skew_stb_gen #(.PULSE_W(P), .SETTLE_CYC(S), .NUM_SAMPLES(N1), .SYNC_STAGES(2)) u_dut1 (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .stb_req_i  (stb_req),
        .stb_o      (stb1),
        .cmp_raw_i  (cmp_raw),
        .stb_valid_o(val1),
        .cmp_out_o  (cmp1),
        .busy_o     (busy1),
`ifdef SKEW_STB_STATS_EN
        .ones_cnt_o (ones1),
`endif
        .ovr_o      (ovr1),
        .ovr_clr_i  (ovr_clr)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mode  = 0;
    int k_ones = 0;

    bit raw_hist [16384];
    int t_acc  [2];
    bit have   [2];
    bit cmp_m  [2];
    bit ovr_m  [2];
    int ones_m [2];
    int n_smp  [2];

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int lat(int i);
        return 1 + P + S + n_smp[i];
    endfunction

    function automatic bit in_win(int i, int lo, int hi);
        return have[i] && (cyc >= t_acc[i] + lo) && (cyc <= t_acc[i] + hi);
    endfunction

    // cmp_s in cycle c reflects cmp_raw_i driven in cycle c-2.
    function automatic int win_ones(int i);
        int sum = 0;
        for (int c = t_acc[i] + 1 + P + S; c <= t_acc[i] + P + S + n_smp[i]; c++) begin
            sum += int'(raw_hist[c - 2]);
        end
        return sum;
    endfunction

    function automatic bit next_raw();
        int c  = cyc + 1;
        int ws = t_acc[0] - 1 + P + S;
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return 1'($urandom % 2);
            3:       return have[0] && (c >= ws) && (c < ws + k_ones);
            default: return (($urandom % 16) < 8);
        endcase
    endfunction

    task automatic go(bit req, bit clr, bit rst);
        bit raw;
        bit busy_now;
        raw = next_raw();
        @(posedge clk);
        cyc++;
        #1;
        arstn   = !rst;
        stb_req = req && !rst;
        cmp_raw = raw;
        ovr_clr = clr;
        raw_hist[cyc] = rst ? 1'b0 : raw;
        if (rst) raw_hist[cyc - 1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                have[i] = 1'b0; cmp_m[i] = 1'b0; ovr_m[i] = 1'b0; ones_m[i] = 0;
            end else if (have[i] && cyc == t_acc[i] + lat(i)) begin
                ones_m[i] = win_ones(i);
                cmp_m[i]  = (ones_m[i] > n_smp[i] / 2);
            end
        end
        @(negedge clk);
        chk("stb0",   stb0,  in_win(0, 1, P));
        chk("busy0",  busy0, in_win(0, 1, lat(0)));
        chk("valid0", val0,  in_win(0, lat(0), lat(0)));
        chk("cmp0",   cmp0,  cmp_m[0]);
        chk("ovr0",   ovr0,  ovr_m[0]);
        chk("stb1",   stb1,  in_win(1, 1, P));
        chk("busy1",  busy1, in_win(1, 1, lat(1)));
        chk("valid1", val1,  in_win(1, lat(1), lat(1)));
        chk("cmp1",   cmp1,  cmp_m[1]);
        chk("ovr1",   ovr1,  ovr_m[1]);
`ifdef SKEW_STB_STATS_EN
        chk("ones0", 32'(ones0), ones_m[0]);
        chk("ones1", 32'(ones1), ones_m[1]);
`endif
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                busy_now = in_win(i, 1, lat(i));
                if (req && busy_now) ovr_m[i] = 1'b1;
                else if (clr)        ovr_m[i] = 1'b0;
                if (req && !busy_now) begin
                    t_acc[i] = cyc;
                    have[i]  = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) go(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        arstn = 1'b0; stb_req = 1'b0; cmp_raw = 1'b0; ovr_clr = 1'b0;
        n_smp[0] = N0; n_smp[1] = N1;
        for (int i = 0; i < 2; i++) begin
            t_acc[i] = 0; have[i] = 0; cmp_m[i] = 0; ovr_m[i] = 0; ones_m[i] = 0;
        end
        cyc = 4;
        repeat (5) go(1'b0, 1'b0, 1'b1);
        // constant high, then constant low comparator
        mode = 0; idle(4); go(1'b1, 1'b0, 1'b0); idle(34);
        mode = 1; go(1'b1, 1'b0, 1'b0); idle(34);
        // exact-count windows: 8 (tie for 16 samples), 7, 11
        mode = 3;
        k_ones = 8;  go(1'b1, 1'b0, 1'b0); idle(34);
        k_ones = 7;  go(1'b1, 1'b0, 1'b0); idle(34);
        k_ones = 11; go(1'b1, 1'b0, 1'b0); idle(34);
        k_ones = 3;  go(1'b1, 1'b0, 1'b0); idle(34);
        // overrun in SAMPLE, clear, clear vs new overrun, request in DONE, back-to-back
        mode = 2;
        go(1'b1, 1'b0, 1'b0); idle(19);
        go(1'b1, 1'b0, 1'b0); idle(3);
        go(1'b0, 1'b1, 1'b0);
        go(1'b1, 1'b1, 1'b0); idle(2);
        go(1'b1, 1'b0, 1'b0);
        go(1'b1, 1'b0, 1'b0); idle(34);
        go(1'b0, 1'b1, 1'b0); idle(2);
        // reset during SETTLE, then a clean request
        mode = 0;
        go(1'b1, 1'b0, 1'b0); idle(7);
        repeat (3) go(1'b0, 1'b0, 1'b1);
        idle(2); go(1'b1, 1'b0, 1'b0); idle(34);
        // randomized segments
        for (int seg = 0; seg < 60; seg++) begin
            mode   = int'($urandom % 5);
            k_ones = int'($urandom_range(0, 16));
            for (int j = 0; j < 50; j++) begin
                go(($urandom % 12) == 0, ($urandom % 25) == 0, ($urandom % 400) == 0);
            end
        end
        idle(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
